// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory with a fixed number of wait
// states, byte/half/word lanes, sign/zero extension and misalignment
// detection. A three-state FSM (IDLE/WAIT/DONE) freezes the pipeline via
// Stall and pulses Ready for one cycle when the access completes.
// Optional feature macro: DMEM_LAST_HIT_EN adds a last-word bypass so that
// an aligned load to the most recently accessed word completes in 1 cycle.
module data_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [1:0]  DM_Sel,
    input  logic        LoadUnsigned,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Stall,
    output logic        Misaligned
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    // FSM and result registers
    logic [1:0]            r_state;
    logic [3:0]            r_count;
    logic [31:0]           r_rdata;
    logic                  r_mis;

    // Request captured in IDLE so that input changes during WAIT are ignored
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_sel;
    logic                  r_uns;
    logic                  r_is_write;

    // Effective access: live inputs while IDLE, captured copy afterwards
    logic [31:0]           w_addr;
    logic [31:0]           w_wdata;
    logic [1:0]            w_sel;
    logic                  w_uns;
    logic                  w_is_write;
    logic                  w_req;
    logic                  w_is_half;
    logic                  w_is_byte;
    logic                  w_mis;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [3:0]            w_be;
    logic [31:0]           w_wlanes;
    logic [31:0]           w_mem_word;
    logic [31:0]           w_src;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;
    logic [1:0]            w_state_next;
    logic [3:0]            w_count_next;
    logic                  w_enter_done;
    logic                  w_commit;
    logic                  w_unused;

`ifdef DMEM_LAST_HIT_EN
    logic                  r_lh_valid;
    logic [DEPTH_LOG2-1:0] r_lh_idx;
    logic [31:0]           r_lh_word;
    logic                  w_lh_hit;
    logic [31:0]           w_new;
`endif

    // Select the access descriptor: inputs in IDLE, captured request otherwise
    always_comb begin
        if (r_state == S_IDLE) begin
            w_addr     = Address;
            w_wdata    = WriteData;
            w_sel      = DM_Sel;
            w_uns      = LoadUnsigned;
            w_is_write = MemWrite;
        end else begin
            w_addr     = r_addr;
            w_wdata    = r_wdata;
            w_sel      = r_sel;
            w_uns      = r_uns;
            w_is_write = r_is_write;
        end
    end

    assign w_req     = MemRead | MemWrite;
    assign w_is_half = (w_sel == 2'b01);
    assign w_is_byte = (w_sel == 2'b10);
    assign w_idx     = w_addr[DEPTH_LOG2+1:2];
    assign w_unused  = &{1'b0, w_addr[31:DEPTH_LOG2+2]};

    // Alignment check, lane enables and lane-replicated store data
    always_comb begin
        w_mis    = 1'b0;
        w_be     = 4'b1111;
        w_wlanes = w_wdata;
        if (w_is_byte) begin
            w_be     = 4'b0001 << w_addr[1:0];
            w_wlanes = {4{w_wdata[7:0]}};
        end else if (w_is_half) begin
            w_mis    = w_addr[0];
            w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{w_wdata[15:0]}};
        end else begin
            w_mis    = |w_addr[1:0];
        end
    end

    // Byte-lane memory: one array per lane so lane writes need no read-modify-write
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem_lane [0:DEPTH-1];

            // Lane write on the edge entering DONE; contents are never reset
            always_ff @(posedge Clk) begin
                if (w_commit && w_be[gi]) begin
                    r_mem_lane[w_idx] <= w_wlanes[8*gi +: 8];
                end
            end

            assign w_mem_word[8*gi +: 8] = r_mem_lane[w_idx];
`ifdef DMEM_LAST_HIT_EN
            assign w_new[8*gi +: 8] = w_be[gi] ? w_wlanes[8*gi +: 8] : w_src[8*gi +: 8];
`endif
        end
    endgenerate

`ifdef DMEM_LAST_HIT_EN
    assign w_lh_hit = r_lh_valid && (r_lh_idx == w_idx);
    assign w_src    = w_lh_hit ? r_lh_word : w_mem_word;
`else
    assign w_src    = w_mem_word;
`endif

    // Load lane extraction with sign or zero extension
    always_comb begin
        case (w_addr[1:0])
            2'd0:    w_byte = w_src[7:0];
            2'd1:    w_byte = w_src[15:8];
            2'd2:    w_byte = w_src[23:16];
            default: w_byte = w_src[31:24];
        endcase
        w_half = w_addr[1] ? w_src[31:16] : w_src[15:0];
        if (w_is_byte) begin
            w_load = {{24{~w_uns & w_byte[7]}}, w_byte};
        end else if (w_is_half) begin
            w_load = {{16{~w_uns & w_half[15]}}, w_half};
        end else begin
            w_load = w_src;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_mis) begin
                        w_state_next = S_DONE;
`ifdef DMEM_LAST_HIT_EN
                    end else if (w_lh_hit && !MemWrite) begin
                        w_state_next = S_DONE;
`endif
                    end else if (WAIT_CYCLES == 0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_WAIT;
                        w_count_next = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_count <= 4'd1) begin
                    w_state_next = S_DONE;
                    w_count_next = 4'd0;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);
    // Reset is also checked here so an access aborted by reset never writes
    assign w_commit     = w_enter_done && w_is_write && !w_mis && !Rst;

    // FSM, request capture and result registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_rdata    <= 32'd0;
            r_mis      <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_sel      <= 2'b00;
            r_uns      <= 1'b0;
            r_is_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (r_state == S_IDLE) begin
                r_addr     <= Address;
                r_wdata    <= WriteData;
                r_sel      <= DM_Sel;
                r_uns      <= LoadUnsigned;
                r_is_write <= MemWrite;
            end
            if (w_enter_done) begin
                r_mis <= w_mis;
                if (w_mis) begin
                    r_rdata <= 32'd0;
                end else if (!w_is_write) begin
                    r_rdata <= w_load;
                end
            end
        end
    end

`ifdef DMEM_LAST_HIT_EN
    // Last-word cache: tracks the most recent aligned access, kept coherent by stores
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_lh_valid <= 1'b0;
            r_lh_idx   <= '0;
            r_lh_word  <= 32'd0;
        end else if (w_enter_done && !w_mis) begin
            r_lh_valid <= 1'b1;
            r_lh_idx   <= w_idx;
            r_lh_word  <= w_is_write ? w_new : w_src;
        end
    end
`endif

    assign ReadData   = r_rdata;
    assign Ready      = (r_state == S_DONE);
    assign Misaligned = Ready & r_mis;
    assign Stall      = ((r_state == S_IDLE) && w_req) || (r_state == S_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder (WAIT_CYCLES=2). Each access is
// driven just after a rising edge; outputs are sampled on falling edges.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  dm_sel;
    logic        load_unsigned;
    logic [31:0] read_data;
    logic        ready;
    logic        stall;
    logic        misaligned;

    int          n_checks = 0;
    int          n_errors = 0;

    int          o_lat;
    logic [31:0] o_rdata;
    logic        o_mis;
    logic [7:0]  o_stall;

`ifdef DMEM_LAST_HIT_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 3;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(10)) dut (
        .Clk          (clk),
        .Rst          (rst),
        .MemRead      (mem_read),
        .MemWrite     (mem_write),
        .Address      (address),
        .WriteData    (write_data),
        .DM_Sel       (dm_sel),
        .LoadUnsigned (load_unsigned),
        .ReadData     (read_data),
        .Ready        (ready),
        .Stall        (stall),
        .Misaligned   (misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access; records latency to Ready, result, error flag and Stall per cycle
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sel, input logic uns);
        @(posedge clk);
        #1;
        mem_read      = rd;
        mem_write     = wr;
        address       = a;
        write_data    = wd;
        dm_sel        = sel;
        load_unsigned = uns;
        o_lat         = -1;
        o_stall       = 8'd0;
        o_rdata       = 32'd0;
        o_mis         = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            o_stall[k] = stall;
            if (ready) begin
                o_lat   = k;
                o_rdata = read_data;
                o_mis   = misaligned;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        $display("access rd=%0d wr=%0d addr=0x%08h wd=0x%08h sel=%0d uns=%0d -> lat=%0d rdata=0x%08h mis=%0d stall=%b",
                 rd, wr, a, wd, sel, uns, o_lat, o_rdata, o_mis, o_stall);
    endtask

    initial begin
        rst           = 1'b1;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        address       = 32'd0;
        write_data    = 32'd0;
        dm_sel        = 2'b00;
        load_unsigned = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset readdata", read_data, 32'd0);
        check("reset ready", {31'd0, ready}, 32'd0);
        check("reset misaligned", {31'd0, misaligned}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Scenario 1: word store then word load, 2 wait states
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0);
        check("s1 store latency", 32'(o_lat), 32'd3);
        check("s1 store stall", {24'd0, o_stall}, 32'h07);
        access(1'b1, 1'b0, 32'h10, 32'd0, 2'b00, 1'b0);
        check("s1 load latency", 32'(o_lat), 32'd3);
        check("s1 load stall", {24'd0, o_stall}, 32'h07);
        check("s1 load data", o_rdata, 32'hDEADBEEF);

        // Scenario 2: byte store into a zero word, signed/unsigned reloads
        access(1'b0, 1'b1, 32'h10, 32'h00000000, 2'b00, 1'b0);
        access(1'b0, 1'b1, 32'h13, 32'h00000080, 2'b10, 1'b0);
        access(1'b1, 1'b0, 32'h13, 32'd0, 2'b10, 1'b0);
        check("s2 byte signed", o_rdata, 32'hFFFFFF80);
        check("s2 byte misaligned", {31'd0, o_mis}, 32'd0);
        access(1'b1, 1'b0, 32'h13, 32'd0, 2'b10, 1'b1);
        check("s2 byte unsigned", o_rdata, 32'h00000080);
        access(1'b1, 1'b0, 32'h10, 32'd0, 2'b00, 1'b0);
        check("s2 word load", o_rdata, 32'h80000000);
        access(1'b1, 1'b0, 32'h12, 32'd0, 2'b01, 1'b0);
        check("s2 half signed", o_rdata, 32'hFFFF8000);
        access(1'b0, 1'b1, 32'h11, 32'h0000007F, 2'b10, 1'b0);
        access(1'b1, 1'b0, 32'h10, 32'd0, 2'b11, 1'b0);
        check("s2 byte lane 1 + sel11 word", o_rdata, 32'h80007F00);

        // Scenario 3: misaligned accesses complete in 1 cycle and leave memory alone
        access(1'b1, 1'b0, 32'h11, 32'd0, 2'b01, 1'b0);
        check("s3 half misaligned flag", {31'd0, o_mis}, 32'd1);
        check("s3 half misaligned data", o_rdata, 32'd0);
        check("s3 half misaligned latency", 32'(o_lat), 32'd1);
        access(1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, 2'b00, 1'b0);
        check("s3 word store misaligned flag", {31'd0, o_mis}, 32'd1);
        access(1'b1, 1'b0, 32'h10, 32'd0, 2'b00, 1'b0);
        check("s3 memory unchanged", o_rdata, 32'h80007F00);
        check("s3 aligned flag clear", {31'd0, o_mis}, 32'd0);

        // Scenario 4: reset in first WAIT cycle aborts the store
        access(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        mem_write  = 1'b1;
        address    = 32'h20;
        write_data = 32'h12345678;
        dm_sel     = 2'b00;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("s4 ready after reset", {31'd0, ready}, 32'd0);
        check("s4 state idle", {30'd0, dut.r_state}, 32'd0);
        check("s4 readdata cleared", read_data, 32'd0);
        mem_write = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        access(1'b1, 1'b0, 32'h20, 32'd0, 2'b00, 1'b0);
        check("s4 old value kept", o_rdata, 32'h0BADF00D);

        // Scenario 5: read+write together is a store; ReadData holds
        access(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 2'b00, 1'b0);
        check("s5 latency", 32'(o_lat), 32'd3);
        check("s5 readdata held", o_rdata, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'h30, 32'd0, 2'b00, 1'b0);
        check("s5 store committed", o_rdata, 32'hA5A5A5A5);

        // Scenario 6: last-word bypass (full latency without the feature)
        access(1'b0, 1'b1, 32'h44, 32'h55667788, 2'b00, 1'b0);
        access(1'b0, 1'b1, 32'h40, 32'h11223344, 2'b00, 1'b0);
        access(1'b1, 1'b0, 32'h40, 32'd0, 2'b00, 1'b0);
        check("s6 hit latency", 32'(o_lat), 32'(HIT_LAT));
        check("s6 hit data", o_rdata, 32'h11223344);
        access(1'b1, 1'b0, 32'h44, 32'd0, 2'b00, 1'b0);
        check("s6 miss latency", 32'(o_lat), 32'd3);
        check("s6 miss data", o_rdata, 32'h55667788);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: access wait states, legal range 0..15.
REQ-002 Parameter DEPTH_LOG2, default 10: word-array depth is 2**DEPTH_LOG2, indexed by Address[DEPTH_LOG2+1:2].
REQ-003 Clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Rst  input  1: asynchronous, active-high reset.
REQ-005 MemRead  input  1: MEM-stage load request, held stable while Stall=1.
REQ-006 MemWrite  input  1: MEM-stage store request, held stable while Stall=1.
REQ-007 Address  input  32: byte address.
REQ-008 WriteData  input  32: store data, right-justified.
REQ-009 DM_Sel  input  2: access size, where 00=word, 01=half, 10=byte, and 11 is treated as word.
REQ-010 LoadUnsigned  input  1: 1 zero-extends half and byte loads; 0 sign-extends them.
REQ-011 ReadData  output  32: load result, valid while Ready=1 and held until the next Ready.
REQ-012 Ready  output  1: one-cycle completion pulse.
REQ-013 Stall  output  1: pipeline freeze request.
REQ-014 Misaligned  output  1: error flag, asserted together with Ready.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-016 IDLE transitions:
- On an aligned request with WAIT_CYCLES>0, go to WAIT and load the counter with WAIT_CYCLES.
- On an aligned request with WAIT_CYCLES=0, go to DONE.
- On a misaligned request, go to DONE.
- With no request, stay in IDLE.
REQ-017 WAIT SHALL decrement the counter each cycle and go to DONE in the cycle after the counter reaches 1, so WAIT lasts exactly WAIT_CYCLES cycles.
REQ-018 DONE SHALL last exactly one cycle with Ready=1, then return to IDLE.
REQ-019 Stall SHALL be a combinational output, defined as (IDLE and (MemRead or MemWrite)) or WAIT, and SHALL be 0 in DONE so the pipeline advances there.
REQ-020 Latency: a request presented at IDLE cycle 0 SHALL produce Ready in cycle WAIT_CYCLES+1.
REQ-021 Alignment rules:
- A half access is misaligned when Address[0]=1.
- A word access is misaligned when Address[1:0]!=0.
- A byte access is never misaligned.
REQ-022 A misaligned access SHALL leave memory unchanged and SHALL set ReadData=0, Misaligned=1 and Ready=1 in DONE.
REQ-023 A store SHALL commit on the edge entering DONE, writing only the addressed lanes:
- byte: lane Address[1:0], data WriteData[7:0];
- half: lanes {Address[1],0} upward, data WriteData[15:0];
- word: all four lanes.
REQ-024 A load SHALL capture ReadData on the edge entering DONE, extracting the same lanes and extending them per LoadUnsigned.
REQ-025 When MemRead and MemWrite are both 1, the access SHALL be a store and ReadData SHALL hold its previous value.
REQ-026 Request inputs SHALL be ignored outside IDLE, so a request change during WAIT has no effect.
REQ-027 A request still asserted in the cycle after DONE SHALL be treated as a new access.
REQ-028 Lane layout SHALL be little-endian: byte 0 is bits [7:0].

Reset
REQ-029 Rst=1 SHALL immediately force the FSM to IDLE and set the counter, ReadData, Ready and Misaligned to 0; Stall SHALL then follow REQ-019.
REQ-030 Reset during WAIT SHALL abort the access, and a pending store SHALL NOT commit.
REQ-031 Memory array contents SHALL NOT be reset.

Configuration
REQ-032 The DMEM_LAST_HIT_EN macro SHALL control a last-word bypass. When defined:
- a valid-tagged register SHALL hold the word index and contents of the last aligned access, kept coherent by stores;
- an aligned load whose word index matches SHALL go from IDLE directly to DONE, with latency 1;
- Rst SHALL clear the valid bit.
REQ-033 When DMEM_LAST_HIT_EN is undefined, no bypass logic SHALL exist and every aligned access SHALL take WAIT_CYCLES+1 cycles.

Verification
REQ-034 Scenario 1: with WAIT_CYCLES=2, store word 0xDEADBEEF to 0x10, then load word from 0x10 -> Ready in cycle 3 of each access, ReadData=0xDEADBEEF, Stall=1 in cycles 0-2.
REQ-035 Scenario 2: store byte 0x80 to 0x13 over 0x00000000, then load byte from 0x13 with LoadUnsigned=0 -> 0xFFFFFF80; repeat the load with LoadUnsigned=1 -> 0x00000080; a word load from 0x10 -> 0x80000000.
REQ-036 Scenario 3: load half from 0x11 -> Misaligned=1, Ready=1, ReadData=0, and memory is unchanged.
REQ-037 Scenario 4: assert Rst in the first WAIT cycle of a word store of 0x12345678 to 0x20 -> state IDLE, Ready=0, and a later load from 0x20 returns the old value.
REQ-038 Scenario 5: assert MemRead and MemWrite together with WriteData 0xA5A5A5A5 at 0x30 -> the store commits and ReadData is unchanged.
REQ-039 Scenario 6 (DMEM_LAST_HIT_EN defined): store to 0x40, then load from 0x40 -> Ready in cycle 1 with the stored data; a load from 0x44 still takes WAIT_CYCLES+1 cycles.
